// File: rtl/sddac_pkg.sv
// Shared helpers for the delta-sigma DAC bank: address width, midscale code and
// second-order integrator widths.
package sddac_pkg;

    function automatic int addr_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int midscale(input int width);
        return 1 << (width - 1);
    endfunction

    function automatic int i1_width(input int width);
        return width + 2;
    endfunction

    function automatic int i2_width(input int width);
        return width + 4;
    endfunction

endpackage

// File: rtl/sddac_channel.sv
// One delta-sigma modulator channel. First order by default; define
// SDDAC_ORDER2_EN to build the second-order modulator instead.
module sddac_channel
    import sddac_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Mute,
    input  logic [WIDTH-1:0] Code,
    output logic             Bit
);

    localparam logic [WIDTH-1:0] MID = WIDTH'(midscale(WIDTH));

    logic bit_q, bit_d;

`ifdef SDDAC_ORDER2_EN
    localparam int I1W = i1_width(WIDTH);
    localparam int I2W = i2_width(WIDTH);

    logic signed [WIDTH:0]   x, fb;
    logic signed [I1W-1:0]   i1_q, i1_d;
    logic signed [I2W-1:0]   i2_q, i2_d;

    // Second integrator consumes the freshly updated first integrator.
    always_comb begin
        x     = signed'({1'b0, Code}) - signed'({1'b0, MID});
        fb    = bit_q ? signed'({1'b0, MID}) : -signed'({1'b0, MID});
        i1_d  = i1_q + I1W'(x) - I1W'(fb);
        i2_d  = i2_q + I2W'(i1_d) - I2W'(fb);
        bit_d = ~i2_d[I2W-1];
    end

    always_ff @(posedge Clk) begin
        if (Reset || Mute) begin
            i1_q  <= '0;
            i2_q  <= '0;
            bit_q <= 1'b0;
        end else begin
            i1_q  <= i1_d;
            i2_q  <= i2_d;
            bit_q <= bit_d;
        end
    end
`else
    logic [WIDTH-1:0] acc_q, acc_d;

    // The adder carry is the output bit, registered with nothing after it.
    always_comb begin
        {bit_d, acc_d} = {1'b0, acc_q} + {1'b0, Code};
    end

    always_ff @(posedge Clk) begin
        if (Reset || Mute) begin
            acc_q <= MID;
            bit_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            bit_q <= bit_d;
        end
    end
`endif

    assign Bit = bit_q;

endmodule

// File: rtl/sddac_bank.sv
// Multi-channel delta-sigma DAC bank with shadow/active code registers and a
// common commit strobe. Optional second order via SDDAC_ORDER2_EN.
module sddac_bank
    import sddac_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int AW       = addr_width(CHANNELS)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [WIDTH-1:0]    Data,
    input  logic [AW-1:0]       Addr,
    input  logic                Write,
    input  logic                Commit,
    input  logic                Mute,
    output logic [CHANNELS-1:0] DACout
);

    logic [WIDTH-1:0] shadow_q [CHANNELS];
    logic [WIDTH-1:0] shadow_d [CHANNELS];
    logic [WIDTH-1:0] active_q [CHANNELS];
    logic [WIDTH-1:0] active_d [CHANNELS];

    // Committing from shadow_d gives the same-cycle write bypass; addresses
    // beyond the last channel match no entry and are dropped.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_d[i] = shadow_q[i];
            if (Write && (Addr == AW'(i))) begin
                shadow_d[i] = Data;
            end
            active_d[i] = Commit ? shadow_d[i] : active_q[i];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        sddac_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .Clk   (Clk),
            .Reset (Reset),
            .Mute  (Mute),
            .Code  (active_q[g]),
            .Bit   (DACout[g])
        );
    end

endmodule

// File: tb/tb_sddac_bank.sv
// Bench for sddac_bank: arithmetic reference model compared every cycle, plus
// directed vectors with hand-computed patterns and ones counts.
module tb_sddac_bank;

    localparam int W   = 8;
    localparam int CH  = 5;
    localparam int MID = 1 << (W - 1);

    logic          clk = 1'b0;
    logic          Reset, Write, Commit, Mute;
    logic [W-1:0]  Data;
    logic [2:0]    Addr;
    logic [CH-1:0] DACout;

    int vectors = 0;
    int miscompares = 0;

    sddac_bank #(
        .WIDTH    (W),
        .CHANNELS (CH)
    ) dut (
        .Clk    (clk),
        .Reset  (Reset),
        .Data   (Data),
        .Addr   (Addr),
        .Write  (Write),
        .Commit (Commit),
        .Mute   (Mute),
        .DACout (DACout)
    );

    always #5 clk = ~clk;

    // Reference model: codes as integers, modulator as plain arithmetic.
    int m_sh [CH];
    int m_act[CH];
    int m_acc[CH];
    int m_i1 [CH];
    int m_i2 [CH];
    logic [CH-1:0] m_out;
    logic started = 1'b0;
    logic [CH-1:0] o;
    int s, xv, fbv, n1, n2;

    function automatic int wrap(input int v, input int w);
        int m;
        int r;
        m = 1 << w;
        r = v & (m - 1);
        return (r >= m / 2) ? r - m : r;
    endfunction

    always @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < CH; i++) begin
                m_sh[i]  <= 0;
                m_act[i] <= 0;
                m_acc[i] <= MID;
                m_i1[i]  <= 0;
                m_i2[i]  <= 0;
            end
            m_out   <= '0;
            started <= 1'b1;
        end else begin
            o = '0;
            for (int i = 0; i < CH; i++) begin
                if (Mute) begin
                    m_acc[i] <= MID;
                    m_i1[i]  <= 0;
                    m_i2[i]  <= 0;
                end else begin
`ifdef SDDAC_ORDER2_EN
                    xv  = m_act[i] - MID;
                    fbv = m_out[i] ? MID : -MID;
                    n1  = wrap(m_i1[i] + xv - fbv, W + 2);
                    n2  = wrap(m_i2[i] + n1 - fbv, W + 4);
                    m_i1[i] <= n1;
                    m_i2[i] <= n2;
                    o[i] = (n2 >= 0);
`else
                    s = m_acc[i] + m_act[i];
                    o[i] = (s >= (1 << W));
                    m_acc[i] <= s % (1 << W);
`endif
                end
                if (Write && Addr == i) m_sh[i] <= Data;
                if (Commit) m_act[i] <= (Write && Addr == i) ? int'(Data) : m_sh[i];
            end
            m_out <= o;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            vectors++;
            if (DACout !== m_out) begin
                miscompares++;
                $display("FAIL model_cmp t=%0t: DACout=%b expected %b", $time, DACout, m_out);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    int cnt[CH];
    int nz;

    task automatic count(input int n);
        for (int i = 0; i < CH; i++) cnt[i] = 0;
        nz = 0;
        repeat (n) begin
            cyc();
            for (int i = 0; i < CH; i++) cnt[i] += int'(DACout[i]);
            if (DACout != '0) nz++;
        end
    endtask

    task automatic pat(input int ch, input logic [3:0] p, input string name);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk(name, int'(DACout[ch]), int'(p[3-k]));
        end
    endtask

    task automatic wr(input int a, input int d, input logic c);
        Write = 1'b1; Addr = 3'(a); Data = W'(d); Commit = c;
        cyc();
        Write = 1'b0; Commit = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Write = 1'b0; Commit = 1'b0; Mute = 1'b0;
        Data = '0; Addr = '0;
        cyc(); cyc();
        chk("reset_out", int'(DACout), 0);
        Reset = 1'b0;
`ifdef SDDAC_ORDER2_EN
        wr(0, 192, 1'b1);
        wr(1, 128, 1'b1);
        wr(2, 100, 1'b1);
        wr(3, 160, 1'b1);
        wr(4, 64, 1'b1);
        count(4096);
        chk("o2_density_192", int'(cnt[0] >= 3070 && cnt[0] <= 3074), 1);
        chk("o2_density_128", int'(cnt[1] >= 2046 && cnt[1] <= 2050), 1);
        chk("o2_density_64", int'(cnt[4] >= 1022 && cnt[4] <= 1026), 1);
        Mute = 1'b1;
        count(10);
        chk("o2_mute", nz, 0);
        Mute = 1'b0;
        count(64);
        Reset = 1'b1;
        cyc();
        chk("o2_reset_stream", int'(DACout), 0);
        Reset = 1'b0;
        count(20);
`else
        cyc();
        chk("idle_zero", int'(DACout), 0);
        wr(0, 128, 1'b0);
        chk("write_no_effect", int'(DACout), 0);
        Commit = 1'b1;
        cyc();
        Commit = 1'b0;
        chk("commit_edge_old_code", int'(DACout[0]), 0);
        pat(0, 4'b1010, "ch0_code128");
        chk("others_idle", int'(DACout[4:1]), 0);

        wr(1, 64, 1'b0);
        Commit = 1'b1;
        cyc();
        Commit = 1'b0;
        pat(1, 4'b0100, "ch1_code64");
        count(256);
        chk("ch1_ones_64", cnt[1], 64);
        chk("ch0_ones_128", cnt[0], 128);

        wr(2, 200, 1'b0);
        count(100);
        chk("ch2_uncommitted", cnt[2], 0);
        Commit = 1'b1;
        cyc();
        Commit = 1'b0;
        count(256);
        chk("ch2_ones_200", cnt[2], 200);

        wr(3, 255, 1'b1);
        count(256);
        chk("ch3_bypass_255", cnt[3], 255);

        wr(5, 255, 1'b0);
        wr(7, 200, 1'b1);
        count(64);
        chk("bad_addr_ch4", cnt[4], 0);
        chk("bad_addr_ch0", cnt[0], 32);

        Mute = 1'b1;
        count(10);
        chk("mute_zero", nz, 0);
        Mute = 1'b0;
        cyc();
        chk("unmute_bit1", int'(DACout), 'b01101);
        cyc();
        chk("unmute_bit2", int'(DACout), 'b01110);

        Reset = 1'b1;
        cyc();
        chk("reset_stream", int'(DACout), 0);
        Reset = 1'b0;
        count(20);
        chk("active_cleared", nz, 0);
        Commit = 1'b1;
        cyc();
        Commit = 1'b0;
        count(20);
        chk("shadow_cleared", nz, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
